// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and coin values for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam int NICKEL_C  = 5;
    localparam int DIME_C    = 10;
    localparam int QUARTER_C = 25;

endpackage

// File: rtl/vend_change_ctr.sv
// rtl/vend_change_ctr.sv - loadable change down-counter stepping by one nickel
module vend_change_ctr
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    input  logic                en,
    output logic                zero,
    output logic                last
);

    logic [CREDIT_W-1:0] value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && !zero) begin
            value <= value - CREDIT_W'(NICKEL_C);
        end
    end

    assign zero = (value == '0);
    assign last = (value == CREDIT_W'(NICKEL_C));

endmodule

// File: rtl/vend_ctrl_change.sv
// rtl/vend_ctrl_change.sv - vending controller with credit, cancel and nickel change
module vend_ctrl_change
    import vend_pkg::*;
#(
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    input  logic                taken,
    output logic                open,
    output logic                nickel_out,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit
);

    if (PRICE <= 0 || (PRICE % 5) != 0) begin : g_bad_price
        $error("vend_ctrl_change: PRICE must be a non-zero multiple of 5");
    end
    if (PRICE + 20 > (2 ** CREDIT_W) - 1) begin : g_bad_width
        $error("vend_ctrl_change: CREDIT_W too narrow for PRICE");
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic                reject_d;
    logic                chg_load, chg_en, chg_zero, chg_last;
    logic [CREDIT_W-1:0] chg_load_val;
    logic [1:0]          coin_cnt;
    logic                coin_any, coin_valid;
    logic [CREDIT_W-1:0] coin_val, sum;

    assign coin_cnt   = 2'(nickel) + 2'(dime) + 2'(quarter);
    assign coin_any   = (coin_cnt != 2'd0);
    assign coin_valid = (coin_cnt == 2'd1);
    assign coin_val   = quarter ? CREDIT_W'(QUARTER_C) :
                        dime    ? CREDIT_W'(DIME_C)    : CREDIT_W'(NICKEL_C);
    assign sum        = credit + coin_val;

    vend_change_ctr #(.CREDIT_W(CREDIT_W)) u_change (
        .clk      (clk),
        .reset    (reset),
        .load     (chg_load),
        .load_val (chg_load_val),
        .en       (chg_en),
        .zero     (chg_zero),
        .last     (chg_last)
    );

    always_comb begin
        state_d      = state_q;
        credit_d     = credit;
        reject_d     = coin_any && !coin_valid;
        chg_load     = 1'b0;
        chg_load_val = '0;
        chg_en       = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                // cancel beats a simultaneous coin, which is handed back
                if (state_q == COLLECT && cancel) begin
                    chg_load     = 1'b1;
                    chg_load_val = credit;
                    credit_d     = '0;
                    state_d      = CHANGE;
                    reject_d     = coin_any;
                end else if (coin_valid) begin
                    if (sum >= CREDIT_W'(PRICE)) begin
                        chg_load     = 1'b1;
                        chg_load_val = sum - CREDIT_W'(PRICE);
                        credit_d     = '0;
                        state_d      = VEND;
                    end else begin
                        credit_d = sum;
                        state_d  = COLLECT;
                    end
                end
            end
            VEND: begin
                reject_d = coin_any;
                if (taken) begin
                    state_d = chg_zero ? IDLE : CHANGE;
                end
            end
            CHANGE: begin
                reject_d = coin_any;
                chg_en   = 1'b1;
                if (chg_last || chg_zero) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
                reject_d = 1'b0;
            end
        endcase
    end

    // outputs are registered from the next state so they line up with the state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            credit      <= '0;
            open        <= 1'b0;
            nickel_out  <= 1'b0;
            coin_reject <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit      <= credit_d;
            open        <= (state_d == VEND);
            nickel_out  <= (state_d == CHANGE);
            coin_reject <= reject_d;
        end
    end

endmodule
